i2c_slave_regfile: RTL and testbench

Register-file adapter that sits between the I2C slave's AXI-stream ports and local control logic. It consumes the slave's write byte stream, using the first byte of each write as a register pointer and the following bytes as auto-incrementing register writes. It feeds the slave's read stream with register contents, auto-incrementing per byte transferred. A local host write port lets fabric logic update status registers.

---
 rtl/i2c_slave_regfile.sv | 81 ++++++++
 tb/tb_i2c_slave_regfile.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// Register file behind an I2C slave's byte streams: the first write byte sets the pointer, the following bytes write registers, and reads return registers; the pointer auto-increments.
// Register/strobe updates land one cycle after the handshake, read data is combinational; wr_tready is high out of reset and read tvalid is held low while a write byte is offered.
module i2c_slave_regfile #(
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS*8-1:0] RESET_VAL = '0,
  localparam int PTR_W = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_axis_wr_tdata,
  input  logic                  s_axis_wr_tvalid,
  output logic                  s_axis_wr_tready,
  input  logic                  s_axis_wr_tlast,
  output logic [7:0]            m_axis_rd_tdata,
  output logic                  m_axis_rd_tvalid,
  input  logic                  m_axis_rd_tready,
  output logic                  m_axis_rd_tlast,
  input  logic                  host_wr_en,
  input  logic [PTR_W-1:0]      host_wr_addr,
  input  logic [7:0]            host_wr_data,
  output logic [NUM_REGS*8-1:0] regs_o,
  output logic [NUM_REGS-1:0]   reg_wr_strobe,
  output logic [NUM_REGS-1:0]   reg_rd_strobe,
  output logic [PTR_W-1:0]      ptr_o
);

  typedef enum logic {ST_PTR, ST_DATA} state_t;

  state_t           state;
  logic             run;
  logic [7:0]       regs [NUM_REGS];
  logic [PTR_W-1:0] ptr;
  logic             wr_acc;
  logic             rd_acc;

  // run stays low through reset and for the first edge after release
  assign s_axis_wr_tready = run;
  assign m_axis_rd_tvalid = run && !s_axis_wr_tvalid;
  assign m_axis_rd_tdata  = regs[ptr];
  assign m_axis_rd_tlast  = 1'b0;
  assign ptr_o            = ptr;

  assign wr_acc = s_axis_wr_tvalid && s_axis_wr_tready;
  assign rd_acc = m_axis_rd_tvalid && m_axis_rd_tready;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*8 +: 8] = regs[g];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL[i*8 +: 8];
      ptr           <= '0;
      state         <= ST_PTR;
      run           <= 1'b0;
      reg_wr_strobe <= '0;
      reg_rd_strobe <= '0;
    end else begin
      run           <= 1'b1;
      reg_wr_strobe <= '0;
      reg_rd_strobe <= '0;
      // host write first so a same-register I2C write below overrides it
      if (host_wr_en) regs[host_wr_addr] <= host_wr_data;
      if (wr_acc) begin
        if (state == ST_PTR) begin
          ptr   <= s_axis_wr_tdata[PTR_W-1:0];
          state <= s_axis_wr_tlast ? ST_PTR : ST_DATA;
        end else begin
          regs[ptr]          <= s_axis_wr_tdata;
          reg_wr_strobe[ptr] <= 1'b1;
          ptr                <= ptr + PTR_W'(1);
          if (s_axis_wr_tlast) state <= ST_PTR;
        end
      end else if (rd_acc) begin
        reg_rd_strobe[ptr] <= 1'b1;
        ptr                <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed plus randomized bench for i2c_slave_regfile, checked against a byte-array model of the register file.
module tb_i2c_slave_regfile;

  localparam int N = 16;
  localparam logic [N*8-1:0] RV = 128'h00000000_0000_3C00_0000_0000_A500_0000;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     wr_tdata = '0;
  logic           wr_tvalid = 1'b0;
  logic           wr_tready;
  logic           wr_tlast = 1'b0;
  logic [7:0]     rd_tdata;
  logic           rd_tvalid;
  logic           rd_tready = 1'b0;
  logic           rd_tlast;
  logic           host_wr_en = 1'b0;
  logic [3:0]     host_wr_addr = '0;
  logic [7:0]     host_wr_data = '0;
  logic [N*8-1:0] regs_o;
  logic [N-1:0]   wr_strobe;
  logic [N-1:0]   rd_strobe;
  logic [3:0]     ptr_o;

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  logic [7:0] mregs [N];
  int         mptr;
  bit         m_in_data;

  always #5 clk = ~clk;

  i2c_slave_regfile #(.NUM_REGS(N), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst),
    .s_axis_wr_tdata(wr_tdata), .s_axis_wr_tvalid(wr_tvalid),
    .s_axis_wr_tready(wr_tready), .s_axis_wr_tlast(wr_tlast),
    .m_axis_rd_tdata(rd_tdata), .m_axis_rd_tvalid(rd_tvalid),
    .m_axis_rd_tready(rd_tready), .m_axis_rd_tlast(rd_tlast),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .regs_o(regs_o), .reg_wr_strobe(wr_strobe), .reg_rd_strobe(rd_strobe), .ptr_o(ptr_o)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < N; i++) f[i*8 +: 8] = mregs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mregs[i] = RV[i*8 +: 8];
    mptr      = 0;
    m_in_data = 1'b0;
  endtask

  task automatic check_state(input string tag, input logic [N-1:0] ewr, input logic [N-1:0] erd);
    chk({tag, ".regs"}, regs_o, model_flat());
    chk({tag, ".ptr"}, ptr_o, mptr);
    chk({tag, ".wstb"}, wr_strobe, ewr);
    chk({tag, ".rstb"}, rd_strobe, erd);
  endtask

  // one write byte, optionally with a concurrent host write and read request
  task automatic wr_byte(input logic [7:0] d, input bit last, input bit hen, input int haddr,
                         input logic [7:0] hdat, input bit rreq);
    logic [N-1:0] ewr;
    bit           i2c_wr;
    wr_tdata = d; wr_tlast = last; wr_tvalid = 1'b1; rd_tready = rreq;
    host_wr_en = hen; host_wr_addr = 4'(haddr); host_wr_data = hdat;
    @(negedge clk);
    chk("wr.tready", wr_tready, 1'b1);
    chk("wr.rd_tvalid_low", rd_tvalid, 1'b0);
    ewr    = '0;
    i2c_wr = m_in_data;
    if (hen && !(i2c_wr && haddr == mptr)) mregs[haddr] = hdat;
    if (!m_in_data) begin
      mptr      = d % N;
      m_in_data = !last;
    end else begin
      mregs[mptr] = d;
      ewr[mptr]   = 1'b1;
      mptr        = (mptr + 1) % N;
      m_in_data   = !last;
    end
    @(posedge clk); #1;
    wr_tvalid = 1'b0; wr_tlast = 1'b0; rd_tready = 1'b0; host_wr_en = 1'b0;
    check_state("wr", ewr, '0);
  endtask

  task automatic rd_byte();
    logic [N-1:0] erd;
    rd_tready = 1'b1;
    @(negedge clk);
    chk("rd.tvalid", rd_tvalid, 1'b1);
    chk("rd.tdata", rd_tdata, mregs[mptr]);
    chk("rd.tlast", rd_tlast, 1'b0);
    erd       = '0;
    erd[mptr] = 1'b1;
    mptr      = (mptr + 1) % N;
    @(posedge clk); #1;
    rd_tready = 1'b0;
    check_state("rd", '0, erd);
  endtask

  task automatic idle(input bit hen, input int haddr, input logic [7:0] hdat);
    host_wr_en = hen; host_wr_addr = 4'(haddr); host_wr_data = hdat;
    if (hen) mregs[haddr] = hdat;
    @(posedge clk); #1;
    host_wr_en = 1'b0;
    check_state("idle", '0, '0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    model_reset();
    #1;
    chk({tag, ".async_regs"}, regs_o, model_flat());
    chk({tag, ".async_ptr"}, ptr_o, 0);
    chk({tag, ".tready_rst"}, wr_tready, 1'b0);
    chk({tag, ".rdvalid_rst"}, rd_tvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk({tag, ".tready_pre"}, wr_tready, 1'b0);
    @(posedge clk); #1;
    chk({tag, ".tready_up"}, wr_tready, 1'b1);
    chk({tag, ".rdvalid_up"}, rd_tvalid, 1'b1);
    check_state(tag, '0, '0);
  endtask

  initial begin
    int len;
    model_reset();
    @(posedge clk); #1;
    chk("reset.rdvalid", rd_tvalid, 1'b0);
    chk("reset.tready", wr_tready, 1'b0);
    check_state("reset", '0, '0);
    do_reset("rst0");

    // pointer + two data bytes
    wr_byte(8'h02, 0, 0, 0, 8'h00, 0);
    wr_byte(8'h11, 0, 0, 0, 8'h00, 0);
    wr_byte(8'h22, 1, 0, 0, 8'h00, 0);
    chk("stream.ptr4", ptr_o, 4'd4);
    idle(0, 0, 8'h00);

    // pointer-only write then three reads
    wr_byte(8'h05, 1, 0, 0, 8'h00, 0);
    repeat (3) rd_byte();
    chk("read.ptr8", ptr_o, 4'd8);

    // masked pointer and wrap on write
    wr_byte(8'hFE, 0, 0, 0, 8'h00, 0);
    wr_byte(8'hAA, 0, 0, 0, 8'h00, 0);
    wr_byte(8'hBB, 0, 0, 0, 8'h00, 0);
    wr_byte(8'hCC, 1, 0, 0, 8'h00, 0);
    chk("wrap.reg0", regs_o[7:0], 8'hCC);

    // wrap on read
    wr_byte(8'h0F, 1, 0, 0, 8'h00, 0);
    rd_byte();
    rd_byte();

    // host/I2C collision and parallel update
    wr_byte(8'h02, 0, 0, 0, 8'h00, 0);
    wr_byte(8'h33, 1, 1, 2, 8'h77, 0);
    chk("coll.reg2", regs_o[23:16], 8'h33);
    wr_byte(8'h02, 0, 0, 0, 8'h00, 0);
    wr_byte(8'h44, 1, 1, 4, 8'h99, 0);
    chk("par.reg4", regs_o[39:32], 8'h99);
    idle(1, 7, 8'h5A);

    // write and read request together: only the write happens
    wr_byte(8'h0A, 1, 0, 0, 8'h00, 1);

    // reset mid-transfer
    wr_byte(8'h01, 0, 0, 0, 8'h00, 0);
    do_reset("rst1");
    wr_byte(8'h09, 1, 0, 0, 8'h00, 0);
    chk("rst1.ptr9", ptr_o, 4'd9);
    chk("rst1.reg9", regs_o[79:72], 8'h3C);

    // randomized traffic
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          len = $urandom_range(0, 5);
          wr_byte(8'($urandom), len == 0, 0, 0, 8'h00, $urandom_range(0, 1));
          for (int k = 0; k < len; k++)
            wr_byte(8'($urandom), k == len - 1, $urandom_range(0, 1),
                    $urandom_range(0, N - 1), 8'($urandom), $urandom_range(0, 1));
        end
        1: repeat ($urandom_range(1, 4)) rd_byte();
        2: idle(1, $urandom_range(0, N - 1), 8'($urandom));
        default: idle(0, 0, 8'h00);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
